// File: rtl/my_xor2_wdff.sv
// Registered bitwise XOR of two operands, delivered through a clock-enabled
// pipeline of PIPE_STAGES registers with an asynchronous active-low reset.
`timescale 1ns/1ps

module my_xor2_wdff #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned PIPE_STAGES = 1,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] IN_A,
  input  logic [WIDTH-1:0] IN_B,
  output logic [WIDTH-1:0] O
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] stage_q [PIPE_STAGES];
  logic [WIDTH-1:0] stage_d [PIPE_STAGES];

  // Stage 0 captures the XOR; every later stage shifts from its predecessor.
  always_comb begin
    stage_d[0] = IN_A ^ IN_B;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // The whole pipeline advances together so CE=0 stretches latency without
  // losing or duplicating data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= RST_V;
      end
    end else if (CE) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign O = stage_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_my_xor2_wdff.sv
// Directed bench for my_xor2_wdff covering three parameterisations side by side.
`timescale 1ns/1ps

module tb_my_xor2_wdff;

  logic clk;
  int   checks;
  int   errors;

  // DUT 0: WIDTH=1, PIPE_STAGES=1, RESET_VALUE=0
  logic       rst0, ce0;
  logic [0:0] a0, b0, o0;
  // DUT 1: WIDTH=8, PIPE_STAGES=3, RESET_VALUE=0
  logic       rst1, ce1;
  logic [7:0] a1, b1, o1;
  // DUT 2: WIDTH=8, PIPE_STAGES=2, RESET_VALUE=0x3C
  logic       rst2, ce2;
  logic [7:0] a2, b2, o2;

  my_xor2_wdff #(.WIDTH(1), .PIPE_STAGES(1), .RESET_VALUE(64'h0)) u_dut0 (
    .CLK(clk), .RESET(rst0), .CE(ce0), .IN_A(a0), .IN_B(b0), .O(o0)
  );
  my_xor2_wdff #(.WIDTH(8), .PIPE_STAGES(3), .RESET_VALUE(64'h0)) u_dut1 (
    .CLK(clk), .RESET(rst1), .CE(ce1), .IN_A(a1), .IN_B(b1), .O(o1)
  );
  my_xor2_wdff #(.WIDTH(8), .PIPE_STAGES(2), .RESET_VALUE(64'h3C)) u_dut2 (
    .CLK(clk), .RESET(rst2), .CE(ce2), .IN_A(a2), .IN_B(b2), .O(o2)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1; ce0 = 1'b0; a0 = '0; b0 = '0;
    rst1 = 1'b1; ce1 = 1'b0; a1 = '0; b1 = '0;
    rst2 = 1'b1; ce2 = 1'b0; a2 = '0; b2 = '0;
    #2;

    // ---------------- DUT 0: reset, truth table, CE hold ----------------
    a0 = 1'b1; b0 = 1'b0; ce0 = 1'b1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    check_val("d0_reset_async", 64'(o0), 64'h0);
    check_val("d2_reset_async", 64'(o2), 64'h3C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("d0_reset_held", 64'(o0), 64'h0);
    end
    rst0 = 1'b0;
    tick();
    rst0 = 1'b1;
    check_val("d0_before_first_edge", 64'(o0), 64'h0);
    tick();
    check_val("d0_first_edge", 64'(o0), 64'h1);

    begin
      logic [1:0] tt_a;
      logic [1:0] tt_b;
      logic [3:0] tt_exp;
      tt_a = 2'b00; tt_b = 2'b00;
      tt_exp = 4'b0110;
      for (int i = 0; i < 4; i++) begin
        {a0, b0} = 2'(i == 0 ? 0 : i == 1 ? 2 : i == 2 ? 1 : 3);
        tt_a = {tt_a[0], a0};
        tt_b = {tt_b[0], b0};
        tick();
        check_val($sformatf("d0_truth_%0d", i), 64'(o0), 64'(tt_exp[i]));
      end
    end

    a0 = 1'b1; b0 = 1'b0;
    tick();
    check_val("d0_hold_setup", 64'(o0), 64'h1);
    ce0 = 1'b0; a0 = 1'b1; b0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("d0_ce_hold", 64'(o0), 64'h1);
    end
    ce0 = 1'b1;
    tick();
    check_val("d0_ce_resume", 64'(o0), 64'h0);
    ce0 = 1'b0;

    // ---------------- DUT 1: pipeline latency ----------------
    rst1 = 1'b1;
    ce1 = 1'b1; a1 = 8'hA5; b1 = 8'h0F;
    tick();
    check_val("d1_lat_e1", 64'(o1), 64'h00);
    a1 = 8'h00; b1 = 8'h00;
    tick();
    check_val("d1_lat_e2", 64'(o1), 64'h00);
    tick();
    check_val("d1_lat_e3", 64'(o1), 64'hAA);
    tick();
    check_val("d1_lat_e4", 64'(o1), 64'h00);

    a1 = 8'h3C; b1 = 8'h96;
    tick();
    check_val("d1_stall_e1", 64'(o1), 64'h00);
    a1 = 8'h00; b1 = 8'h00;
    tick();
    check_val("d1_stall_e2", 64'(o1), 64'h00);
    ce1 = 1'b0; a1 = 8'hFF; b1 = 8'h01;
    tick();
    check_val("d1_stall_hold1", 64'(o1), 64'h00);
    tick();
    check_val("d1_stall_hold2", 64'(o1), 64'h00);
    ce1 = 1'b1; a1 = 8'h00; b1 = 8'h00;
    tick();
    check_val("d1_stall_e3", 64'(o1), 64'hAA);
    tick();
    check_val("d1_stall_after", 64'(o1), 64'h00);
    ce1 = 1'b0;

    // ---------------- DUT 2: non-zero reset value, mid-op reset ----------------
    ce2 = 1'b1; a2 = 8'hFF; b2 = 8'h00;
    tick();
    check_val("d2_reset_wins_edge", 64'(o2), 64'h3C);
    rst2 = 1'b1; ce2 = 1'b0;
    tick();
    check_val("d2_release_ce0", 64'(o2), 64'h3C);
    ce2 = 1'b1;
    tick();
    check_val("d2_rv_e1", 64'(o2), 64'h3C);
    a2 = 8'h55; b2 = 8'h00;
    tick();
    check_val("d2_load_ff", 64'(o2), 64'hFF);
    a2 = 8'h00; b2 = 8'h00;
    #2;
    rst2 = 1'b0;
    #0.05;
    check_val("d2_midop_async", 64'(o2), 64'h3C);
    #0.05;
    rst2 = 1'b1;
    #0.1;
    check_val("d2_after_pulse", 64'(o2), 64'h3C);
    tick();
    check_val("d2_post_e1", 64'(o2), 64'h3C);
    tick();
    check_val("d2_post_e2", 64'(o2), 64'h00);
    tick();
    check_val("d2_post_e3", 64'(o2), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_xor2_wdff.md
Name: my_xor2_wdff

Overview:
Registered two-input bitwise XOR with clock enable and asynchronous reset. Computes IN_A ^ IN_B and delivers it through a clock-enabled register pipeline of configurable depth. Used as a glitch-free, clock-aligned XOR primitive in datapaths that need the result on register boundaries only.

Parameters:
WIDTH, 1, bit width of IN_A, IN_B and O (legal 1..64).
PIPE_STAGES, 1, number of CE-gated register stages between the XOR and O (legal 1..4).
RESET_VALUE, 0, value loaded into every pipeline stage on reset (WIDTH bits, zero-extended/truncated).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset; 0 = reset asserted.
CE  input  1  clock enable, sampled on rising CLK edge; 1 = advance pipeline.
IN_A  input  WIDTH  XOR operand A.
IN_B  input  WIDTH  XOR operand B.
O  output  WIDTH  registered XOR result, driven directly from the last pipeline stage.

Behaviour:
- Falling edge of RESET immediately (no clock needed) sets all stages, and therefore O, to RESET_VALUE; state is held there while RESET=0, regardless of CLK/CE/inputs.
- RESET deassertion is not synchronised inside the block; the integrator supplies a release that is synchronous to CLK. First update occurs on the first rising CLK edge with RESET=1.
- Rising CLK, RESET=1, CE=1: stage1 <= IN_A ^ IN_B (bitwise, WIDTH bits, no carry); stage k <= stage k-1 for k=2..PIPE_STAGES.
- Rising CLK, RESET=1, CE=0: all stages hold; O unchanged. Input changes while CE=0 are ignored.
- Latency: a value of IN_A ^ IN_B sampled on a CE=1 edge appears on O after PIPE_STAGES CE=1 edges (PIPE_STAGES=1: O valid just after that same edge). Cycles with CE=0 stretch the latency; no data lost or duplicated.
- O is purely registered; no combinational path from IN_A/IN_B/CE to O.
- Inputs changing between clock edges have no effect; only values at the rising edge matter.
- Reset mid-operation: all in-flight pipeline data discarded; after release, O shows RESET_VALUE until PIPE_STAGES CE=1 edges have elapsed.
- RESET low coinciding with a rising CLK edge: reset wins.
- No X propagation from an uninitialised state: the design must be reset before use; behaviour before the first reset is undefined.

Test Plan:
- Reset: RESET=0 with IN_A=1, IN_B=0, CE=1, clocks running -> O=0 immediately and throughout; release RESET -> O=1 after first CE=1 edge (WIDTH=1, PIPE_STAGES=1).
- Truth table: CE=1, drive (A,B) = (0,0),(1,0),(0,1),(1,1) one per cycle -> O = 0,1,1,0 one edge later each.
- Clock enable hold: O=1, set CE=0, change to A=1,B=1 for 10 cycles -> O stays 1; raise CE -> O=0 after next edge.
- Pipeline latency: PIPE_STAGES=3, WIDTH=8, A=0xA5, B=0x0F on one CE=1 edge then A=B=0 -> O=0x00 for two edges, 0xAA on third edge, then 0x00; insert CE=0 cycles mid-flight -> 0xAA delayed by exactly that many cycles.
- Reset mid-operation: PIPE_STAGES=2, load 0xFF then pulse RESET low for 100 ps between edges -> O=RESET_VALUE at once, asynchronously; pre-reset data never appears on O.
- Non-zero reset value: RESET_VALUE=0x3C, WIDTH=8 -> O=0x3C during reset and until first CE=1 edge after release.
